// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Round-robin arbiter and sequencer that shares one signed serial-parallel
//   multiplier among NUM_REQ requesters. It accepts operand pairs over
//   per-requester valid/ready handshakes. It drives the multiplier's
//   level-sensitive start/done protocol and returns each 16-bit product
//   tagged with the index of the requester that sent it.
//
// Handshake: a request transfers on a rising clk edge where
//   req_valid_i[i] & req_ready_o[i]. req_ready_o is one-hot, combinational,
//   and only ever asserted in IDLE. A requester holds its operands while
//   valid and not ready, and may drop valid to withdraw. resp_valid_o is a
//   one-cycle pulse with no backpressure.
//
// Optional feature: define MULT_ARB_ZERO_BYPASS_EN to answer requests that
//   have a zero operand directly from IDLE, without using the multiplier.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid_i     per-requester request pending
//   req_a_i/req_b_i packed signed operands, requester i at [8i+7:8i]
//   req_ready_o     one-hot accept
//   resp_valid_o    product available (one-cycle pulse)
//   resp_id_o       requester index of resp_product_o
//   resp_product_o  signed 16-bit product
//   busy_o          high whenever the FSM is not IDLE
//   mul_start_o     level start to the multiplier
//   mul_a_o/mul_b_o operands to the multiplier, held while start/done high
//   mul_product_i   multiplier result
//   mul_done_i      multiplier completion level
//   state_o         debug view of the FSM state (0 IDLE, 1 RUN, 2 DRAIN)
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_a_i,
  input  logic [8*NUM_REQ-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   resp_valid_o,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [15:0]            resp_product_o,
  output logic                   busy_o,
  output logic                   mul_start_o,
  output logic [7:0]             mul_a_o,
  output logic [7:0]             mul_b_o,
  input  logic [15:0]            mul_product_i,
  input  logic                   mul_done_i,
  output logic [1:0]             state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] cur_id_q;
  logic             resp_valid_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [15:0]      resp_product_q;
  logic             mul_start_q;
  logic [7:0]       mul_a_q;
  logic [7:0]       mul_b_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  int               cand_sum;
  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic             bypass;

  // Round-robin search starting at last_grant+1 with wrap. The last winner
  // is visited last, so it only wins again when nobody else is valid.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = int'(last_grant_q) + k;
      if (cand_sum >= NUM_REQ) cand_sum = cand_sum - NUM_REQ;
      if (!grant_found && req_valid_i[cand_sum[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  assign sel_a = req_a_i[8*grant_idx +: 8];
  assign sel_b = req_b_i[8*grant_idx +: 8];

`ifdef MULT_ARB_ZERO_BYPASS_EN
  // A zero operand makes the product trivially zero; answer from IDLE.
  assign bypass = (sel_a == 8'h00) || (sel_b == 8'h00);
`else
  assign bypass = 1'b0;
`endif

  // Ready is only offered in IDLE and is forced low during reset.
  always_comb begin
    req_ready_o = '0;
    if (!rst && (state_q == IDLE) && grant_found) req_ready_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      cur_id_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            last_grant_q <= grant_idx;
            if (bypass) begin
              resp_valid_q   <= 1'b1;
              resp_product_q <= '0;
              resp_id_q      <= ID_W'(grant_idx);
            end else begin
              cur_id_q    <= grant_idx;
              mul_a_q     <= sel_a;
              mul_b_q     <= sel_b;
              mul_start_q <= 1'b1;
              state_q     <= RUN;
            end
          end
        end
        RUN: begin
          if (mul_done_i) begin
            resp_valid_q   <= 1'b1;
            resp_product_q <= mul_product_i;
            resp_id_q      <= ID_W'(cur_id_q);
            mul_start_q    <= 1'b0;
            state_q        <= DRAIN;
          end
        end
        DRAIN: begin
          // Operands stay put until the multiplier releases done.
          if (!mul_done_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_id_o      = resp_id_q;
  assign resp_product_o = resp_product_q;
  assign busy_o         = (state_q != IDLE);
  assign mul_start_o    = mul_start_q;
  assign mul_a_o        = mul_a_q;
  assign mul_b_o        = mul_b_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: directed steps, a behavioural multiplier
// with configurable latency, and a scoreboard of expected {id, product}.
module tb_mult_share_arbiter;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int W = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_product;
  logic        busy;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        mul_done;
  logic [1:0]  state_dbg;

  mult_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_ready_o    (req_ready),
    .resp_valid_o   (resp_valid),
    .resp_id_o      (resp_id),
    .resp_product_o (resp_product),
    .busy_o         (busy),
    .mul_start_o    (mul_start),
    .mul_a_o        (mul_a),
    .mul_b_o        (mul_b),
    .mul_product_i  (mul_product),
    .mul_done_i     (mul_done),
    .state_o        (state_dbg)
  );

  // ---------------- multiplier model ----------------
  int mdl_lat = 3;
  int mdl_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done    <= 1'b0;
      mul_product <= '0;
      mdl_cnt     <= 0;
    end else if (mul_start && !mul_done) begin
      if (mdl_cnt >= mdl_lat - 1) begin
        mul_done    <= 1'b1;
        mul_product <= 16'($signed(mul_a) * $signed(mul_b));
        mdl_cnt     <= 0;
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end else if (!mul_start) begin
      mul_done <= 1'b0;
      mdl_cnt  <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int resp_count = 0;
  int start_rises = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [15:0] prod);
    exp_q.push_back({2'(id), prod});
  endtask

  logic         prev_start;
  logic         prev_done;
  logic [7:0]   prev_a;
  logic [7:0]   prev_b;
  logic [W-1:0] sb_e;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_start <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      if (resp_valid) begin
        resp_count++;
        chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          chk("resp_id", 32'(resp_id), 32'(sb_e[17:16]));
          chk("resp_product", 32'(resp_product), 32'(sb_e[15:0]));
        end
      end
      if (busy) chk("no_grant_while_busy", 32'(req_ready), 32'd0);
      if (prev_start && prev_done) begin
        chk("start_falls_after_done", 32'(mul_start), 32'd0);
        chk("resp_after_done", 32'(resp_valid), 32'd1);
      end
      if ((mul_start || mul_done) && (prev_start || prev_done)) begin
        chk("hold_mul_a", 32'(mul_a), 32'(prev_a));
        chk("hold_mul_b", 32'(mul_b), 32'(prev_b));
      end
      if (mul_start && !prev_start) start_rises++;
      prev_start <= mul_start;
      prev_done  <= mul_done;
      prev_a     <= mul_a;
      prev_b     <= mul_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_valid[id]    = 1'b1;
  endtask

  // Wait for an accept, check it went to the expected requester, then step
  // past the accepting edge and optionally drop that requester's valid.
  task automatic wait_accept(input int id, input bit drop);
    int n = 0;
    @(negedge clk);
    while (((req_valid & req_ready) == 4'd0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("grant_to_%0d", id), 32'(req_ready), 32'(4'b0001 << id));
    @(posedge clk);
    #1;
    if (drop) req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_resp_product"}, 32'(resp_product), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r0;
    int c0;
    rst       = 1'b1;
    req_valid = 4'h0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset: valid requests must not be offered ready while rst is high.
    req_valid = 4'hF;
    #1;
    chk_all_zero("reset");
    req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");

    // 1: requester 0, 3*5
    @(posedge clk); #1;
    c0 = resp_count;
    set_req(0, 8'h03, 8'h05);
    push(0, 16'h000F);
    wait_accept(0, 1'b1);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_mul_start", 32'(mul_start), 32'd1);
    chk("t1_mul_a", 32'(mul_a), 32'h03);
    wait_idle("t1");
    chk("t1_one_pulse", 32'(resp_count - c0), 32'd1);

    // 2: requester 1, -3*5, longer multiplier latency
    mdl_lat = 4;
    @(posedge clk); #1;
    set_req(1, 8'hFD, 8'h05);
    push(1, 16'hFFF1);
    wait_accept(1, 1'b1);
    @(negedge clk);
    chk("t2_mul_a", 32'(mul_a), 32'hFD);
    chk("t2_mul_b", 32'(mul_b), 32'h05);
    wait_idle("t2");

    // 3: all four valid right after a reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mdl_lat = 2;
    @(posedge clk); #1;
    set_req(0, 8'h02, 8'h03);
    set_req(1, 8'hFC, 8'h05);
    set_req(2, 8'h07, 8'hF9);
    set_req(3, 8'hF8, 8'hF8);
    push(0, 16'h0006);
    push(1, 16'hFFEC);
    push(2, 16'hFFCF);
    push(3, 16'h0040);
    for (int i = 0; i < 4; i++) wait_accept(i, 1'b1);
    wait_idle("t3");

    // 4: requesters 0 and 2 held continuously
    mdl_lat = 1;
    @(posedge clk); #1;
    set_req(0, 8'h01, 8'h02);
    set_req(2, 8'hFF, 8'h06);
    for (int i = 0; i < 2; i++) begin
      push(0, 16'h0002);
      push(2, 16'hFFFA);
    end
    wait_accept(0, 1'b0);
    wait_accept(2, 1'b0);
    wait_accept(0, 1'b0);
    wait_accept(2, 1'b0);
    req_valid = 4'h0;
    wait_idle("t4");

    // 5: zero operand
    mdl_lat = 3;
    r0 = start_rises;
    @(posedge clk); #1;
    set_req(3, 8'h00, 8'h7F);
    push(3, 16'h0000);
    wait_accept(3, 1'b1);
    @(negedge clk);
    chk("t5_resp_timing", 32'(resp_valid), 32'(BYP));
    chk("t5_busy", 32'(busy), 32'(!BYP));
    wait_idle("t5");
    chk("t5_start_rises", 32'(start_rises - r0), BYP ? 32'd0 : 32'd1);

    // 6: reset in RUN aborts without a response, then recovery
    mdl_lat = 6;
    @(posedge clk); #1;
    set_req(1, 8'h11, 8'h02);
    wait_accept(1, 1'b1);
    @(negedge clk);
    chk("t6_in_run", 32'(state_dbg), 32'd1);
    @(negedge clk);
    c0 = resp_count;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_no_resp", 32'(resp_count - c0), 32'd0);
    chk("t6_idle", 32'(state_dbg), 32'd0);
    mdl_lat = 2;
    @(posedge clk); #1;
    set_req(2, 8'h10, 8'h10);
    push(2, 16'h0100);
    wait_accept(2, 1'b1);
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
